frame_swap_ctrl: RTL and testbench
==================================

FRAME_SWAP_CTRL -- requirements
Module: frame_swap_ctrl

Interface
REQ-001 The block SHALL provide parameter X_WIDTH, default 200, meaning stored frame width in pixels.
REQ-002 The block SHALL provide parameter Y_HEIGHT, default 150, meaning stored frame height in lines.
REQ-003 The block SHALL provide parameter NUM_FRAMES, default 6572, meaning frames to display before DONE; 0 means run forever.
REQ-004 The block SHALL have port CLK_40, input, 1, system clock; reset is synchronous, active-high, on CLK_40.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1, single-cycle pulse that begins streaming from IDLE.
REQ-007 The block SHALL have port abort, input, 1, level that forces a return to IDLE.
REQ-008 The block SHALL have port bit_valid, input, 1, one-cycle strobe per received pixel bit from the SPI receiver.
REQ-009 The block SHALL have port frame_end, input, 1, one-cycle pulse at the start of VGA vertical blank.
REQ-010 The block SHALL have port spi_req, output, 1, requests the SPI master to keep streaming.
REQ-011 The block SHALL have port wr_en, output, 1, back-bank write enable.
REQ-012 The block SHALL have ports wr_x and wr_y, output, clog2(X_WIDTH) and clog2(Y_HEIGHT), write pixel address.
REQ-013 The block SHALL have port rd_bank_sel, output, 1, bank being displayed; the write bank is always its inverse.
REQ-014 The block SHALL have ports swap, output, 1, one-cycle pulse on bank exchange; and done, output, 1, level once NUM_FRAMES are shown.
REQ-015 The block SHALL have port frames_shown, output, 16, count of swaps since start, wrapping at 65535 to 0.

Function
REQ-016 The FSM SHALL have states IDLE, FILL, READY, SWAP, DONE.
REQ-017 IDLE->FILL SHALL occur on start; start is ignored in any other state.
REQ-018 In FILL, spi_req SHALL be 1 and wr_en SHALL equal bit_valid combinationally; spi_req is 0 in all other states.
REQ-019 On each bit_valid in FILL, wr_x SHALL increment; at X_WIDTH-1 it wraps to 0 and wr_y increments.
REQ-020 The bit_valid that writes (X_WIDTH-1, Y_HEIGHT-1) SHALL move FILL->READY and clear wr_x/wr_y to 0.
REQ-021 bit_valid outside FILL SHALL be ignored: no write, no address change.
REQ-022 READY->SWAP SHALL occur on frame_end; SWAP lasts exactly one cycle with swap=1, then rd_bank_sel toggles and frames_shown increments on the same edge.
REQ-023 From SWAP the next state SHALL be DONE if NUM_FRAMES!=0 and the incremented frames_shown equals NUM_FRAMES, else FILL.
REQ-024 frame_end in FILL (underrun) SHALL leave rd_bank_sel unchanged, so the display repeats the previous frame; FILL continues.
REQ-025 frame_end coincident with the final bit_valid SHALL be treated as an underrun; the swap waits for the next frame_end.
REQ-026 DONE SHALL hold done=1 until reset or abort; DONE ignores start.
REQ-027 abort SHALL move any state to IDLE next cycle, clear wr_x, wr_y, frames_shown and done, keep rd_bank_sel, and take priority over all other inputs.

Reset
REQ-028 On reset, state SHALL be IDLE, and spi_req, wr_en, swap, done, wr_x, wr_y, rd_bank_sel and frames_shown SHALL all be 0.
REQ-029 Reset mid-FILL SHALL discard the partial frame; the next start refills from (0,0) into bank 1.

Configuration
REQ-030 With macro FRAME_SWAP_CTRL_UNDERRUN_CNT_EN defined, the block SHALL add output underrun_cnt, 16 bits, which increments per REQ-024/025 event, saturates at 65535, and clears on reset, abort or start.
REQ-031 Without FRAME_SWAP_CTRL_UNDERRUN_CNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification (X_WIDTH=4, Y_HEIGHT=2, NUM_FRAMES=2)
REQ-032 Bench: reset, start, 8 bit_valid -> wr_en high 8 times, addresses (0,0)..(3,1), state READY, spi_req=0.
REQ-033 Bench: READY then frame_end -> swap=1 for 1 cycle, rd_bank_sel 0->1, frames_shown=1, spi_req=1 again.
REQ-034 Bench: frame_end after 5 bits of FILL -> rd_bank_sel unchanged, underrun_cnt=1, remaining 3 bits still fill; the next frame_end swaps.
REQ-035 Bench: final bit_valid and frame_end in the same cycle -> no swap, underrun_cnt+1, swap on the following frame_end.
REQ-036 Bench: complete 2 swaps -> done=1, spi_req=0; further start and bit_valid are ignored.
REQ-037 Bench: abort after 3 bits of the second fill -> IDLE, wr_x=wr_y=0, frames_shown=0, rd_bank_sel retains 1.

Source files
------------

// File: rtl/frame_swap_ctrl.sv
// -----------------------------------------------------------------------------
// frame_swap_ctrl
//
// Double-buffered frame controller between an SPI pixel receiver and a VGA
// scan-out. While the back bank is being filled from the SPI stream, the
// front bank (rd_bank_sel) is displayed. A completed frame is promoted to the
// front at the next vertical blank. If vertical blank arrives before the back
// bank is complete (underrun), the display repeats the previous frame and the
// fill simply continues.
//
// Parameters
//   X_WIDTH     stored frame width in pixels
//   Y_HEIGHT    stored frame height in lines
//   NUM_FRAMES  frames to display before DONE; 0 runs forever
//
// Ports
//   CLK_40        in   system clock
//   reset         in   synchronous active-high reset
//   start         in   one-cycle pulse, begins streaming from IDLE
//   abort         in   level, forces return to IDLE (highest priority)
//   bit_valid     in   one-cycle strobe per received pixel bit
//   frame_end     in   one-cycle pulse at start of VGA vertical blank
//   spi_req       out  keep the SPI master streaming (high only while filling)
//   wr_en         out  back-bank write enable
//   wr_x / wr_y   out  back-bank write address
//   rd_bank_sel   out  bank on display; write bank is its inverse
//   swap          out  one-cycle pulse on bank exchange
//   done          out  high once NUM_FRAMES frames have been shown
//   frames_shown  out  swaps since start, wraps at 65535
//   underrun_cnt  out  (only with FRAME_SWAP_CTRL_UNDERRUN_CNT_EN) saturating
//                      count of underrun events, cleared by reset/abort/start
//
// Build option: define FRAME_SWAP_CTRL_UNDERRUN_CNT_EN to add underrun_cnt.
// -----------------------------------------------------------------------------
module frame_swap_ctrl #(
  parameter int X_WIDTH    = 200,
  parameter int Y_HEIGHT   = 150,
  parameter int NUM_FRAMES = 6572,
  localparam int XW = (X_WIDTH  > 1) ? $clog2(X_WIDTH)  : 1,
  localparam int YW = (Y_HEIGHT > 1) ? $clog2(Y_HEIGHT) : 1
) (
  input  logic          CLK_40,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          bit_valid,
  input  logic          frame_end,
  output logic          spi_req,
  output logic          wr_en,
  output logic [XW-1:0] wr_x,
  output logic [YW-1:0] wr_y,
  output logic          rd_bank_sel,
  output logic          swap,
  output logic          done,
  output logic [15:0]   frames_shown
`ifdef FRAME_SWAP_CTRL_UNDERRUN_CNT_EN
  ,
  output logic [15:0]   underrun_cnt
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_READY = 3'd2,
    ST_SWAP  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [XW-1:0] X_LAST        = XW'(X_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST        = YW'(Y_HEIGHT - 1);
  localparam logic [15:0]   FRAMES_TARGET = 16'(NUM_FRAMES);
  localparam logic          RUN_FOREVER   = (NUM_FRAMES == 0);

  state_t        state_r, state_nxt_s;
  logic [XW-1:0] wr_x_r, wr_x_nxt_s;
  logic [YW-1:0] wr_y_r, wr_y_nxt_s;
  logic          rd_bank_r, rd_bank_nxt_s;
  logic [15:0]   frames_r, frames_nxt_s;
  logic [15:0]   frames_inc_s;

  assign frames_inc_s = frames_r + 16'd1;

  // State and datapath registers.
  always_ff @(posedge CLK_40) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      wr_x_r    <= '0;
      wr_y_r    <= '0;
      rd_bank_r <= 1'b0;
      frames_r  <= 16'd0;
    end else begin
      state_r   <= state_nxt_s;
      wr_x_r    <= wr_x_nxt_s;
      wr_y_r    <= wr_y_nxt_s;
      rd_bank_r <= rd_bank_nxt_s;
      frames_r  <= frames_nxt_s;
    end
  end

  // Next-state, next-datapath and state-decoded outputs.
  always_comb begin
    state_nxt_s   = state_r;
    wr_x_nxt_s    = wr_x_r;
    wr_y_nxt_s    = wr_y_r;
    rd_bank_nxt_s = rd_bank_r;
    frames_nxt_s  = frames_r;
    spi_req       = 1'b0;
    wr_en         = 1'b0;
    swap          = 1'b0;
    done          = 1'b0;

    case (state_r)
      ST_FILL: begin
        spi_req = 1'b1;
        wr_en   = bit_valid;
      end
      ST_SWAP: begin
        swap = 1'b1;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        spi_req = 1'b0;
      end
    endcase

    // abort overrides every input; the displayed bank is kept so the
    // screen keeps showing the last completed frame.
    if (abort) begin
      state_nxt_s  = ST_IDLE;
      wr_x_nxt_s   = '0;
      wr_y_nxt_s   = '0;
      frames_nxt_s = 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_nxt_s  = ST_FILL;
            wr_x_nxt_s   = '0;
            wr_y_nxt_s   = '0;
            frames_nxt_s = 16'd0;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_FILL: begin
          // frame_end here is an underrun: nothing changes on the display
          // side. That includes frame_end landing on the last pixel - the
          // frame then waits in READY for the following blank.
          if (bit_valid) begin
            if (wr_x_r == X_LAST) begin
              wr_x_nxt_s = '0;
              if (wr_y_r == Y_LAST) begin
                wr_y_nxt_s  = '0;
                state_nxt_s = ST_READY;
              end else begin
                wr_y_nxt_s = wr_y_r + YW'(1);
              end
            end else begin
              wr_x_nxt_s = wr_x_r + XW'(1);
            end
          end else begin
            state_nxt_s = ST_FILL;
          end
        end
        ST_READY: begin
          if (frame_end) begin
            state_nxt_s = ST_SWAP;
          end else begin
            state_nxt_s = ST_READY;
          end
        end
        ST_SWAP: begin
          rd_bank_nxt_s = ~rd_bank_r;
          frames_nxt_s  = frames_inc_s;
          if (!RUN_FOREVER && (frames_inc_s == FRAMES_TARGET)) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_FILL;
          end
        end
        ST_DONE: begin
          state_nxt_s = ST_DONE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
          wr_x_nxt_s  = '0;
          wr_y_nxt_s  = '0;
        end
      endcase
    end
  end

  assign wr_x         = wr_x_r;
  assign wr_y         = wr_y_r;
  assign rd_bank_sel  = rd_bank_r;
  assign frames_shown = frames_r;

`ifdef FRAME_SWAP_CTRL_UNDERRUN_CNT_EN
  logic [15:0] underrun_r;

  // Saturating count of vertical blanks that found the back bank incomplete.
  always_ff @(posedge CLK_40) begin
    if (reset) begin
      underrun_r <= 16'd0;
    end else if (abort) begin
      underrun_r <= 16'd0;
    end else if ((state_r == ST_IDLE) && start) begin
      underrun_r <= 16'd0;
    end else if ((state_r == ST_FILL) && frame_end && (underrun_r != 16'hFFFF)) begin
      underrun_r <= underrun_r + 16'd1;
    end else begin
      underrun_r <= underrun_r;
    end
  end

  assign underrun_cnt = underrun_r;
`else
  // Underrun counter not built in this configuration.
`endif

endmodule

// File: tb/tb_frame_swap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frame_swap_ctrl
//
// Self-checking bench for frame_swap_ctrl with a 4x2 frame and a two-frame
// run. A table of directed vectors covers fill, swap, underrun, DONE, abort
// and reset-mid-fill; a randomized phase is then checked cycle by cycle
// against a behavioural model that tracks a linear pixel index.
// Inputs change on the falling edge; outputs are sampled 2 ns later.
// -----------------------------------------------------------------------------
module tb_frame_swap_ctrl;

  localparam int XN = 4;
  localparam int YN = 2;
  localparam int NF = 2;

  logic        CLK_40 = 1'b0;
  logic        reset, start, abort, bit_valid, frame_end;
  logic        spi_req, wr_en, rd_bank_sel, swap, done;
  logic [1:0]  wr_x;
  logic [0:0]  wr_y;
  logic [15:0] frames_shown;
`ifdef FRAME_SWAP_CTRL_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  always #5 CLK_40 = ~CLK_40;

  frame_swap_ctrl #(.X_WIDTH(XN), .Y_HEIGHT(YN), .NUM_FRAMES(NF)) dut (
    .CLK_40       (CLK_40),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .bit_valid    (bit_valid),
    .frame_end    (frame_end),
    .spi_req      (spi_req),
    .wr_en        (wr_en),
    .wr_x         (wr_x),
    .wr_y         (wr_y),
    .rd_bank_sel  (rd_bank_sel),
    .swap         (swap),
    .done         (done),
    .frames_shown (frames_shown)
`ifdef FRAME_SWAP_CTRL_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  typedef struct {
    int rs, st, ab, bv, fe;
    int we, x, y, spi, sw, bk, fr, dn, und;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  // model state: mode 0 idle, 1 fill, 2 ready, 3 swap, 4 done
  int m_mode, m_pix, m_bank, m_frames, m_und;

  task automatic add(input int rs, st, ab, bv, fe, we, x, y, spi, sw, bk, fr, dn, und);
    vec_t v;
    v.rs = rs; v.st = st; v.ab = ab; v.bv = bv; v.fe = fe;
    v.we = we; v.x = x; v.y = y; v.spi = spi; v.sw = sw;
    v.bk = bk; v.fr = fr; v.dn = dn; v.und = und;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input int rs, st, ab, bv, fe);
    reset     = (rs != 0);
    start     = (st != 0);
    abort     = (ab != 0);
    bit_valid = (bv != 0);
    frame_end = (fe != 0);
  endtask

  task automatic check_outputs(input string tag, input int we, x, y, spi, sw, bk, fr, dn, und);
    check({tag, " wr_en"},        32'(wr_en),        32'(we));
    check({tag, " wr_x"},         32'(wr_x),         32'(x));
    check({tag, " wr_y"},         32'(wr_y),         32'(y));
    check({tag, " spi_req"},      32'(spi_req),      32'(spi));
    check({tag, " swap"},         32'(swap),         32'(sw));
    check({tag, " rd_bank_sel"},  32'(rd_bank_sel),  32'(bk));
    check({tag, " frames_shown"}, 32'(frames_shown), 32'(fr));
    check({tag, " done"},         32'(done),         32'(dn));
`ifdef FRAME_SWAP_CTRL_UNDERRUN_CNT_EN
    check({tag, " underrun_cnt"}, 32'(underrun_cnt), 32'(und));
`else
    if (und < 0) $display("unexpected negative underrun expectation");
`endif
  endtask

  // Behavioural model: advance one clock with the given inputs.
  task automatic model_step(input int rs, st, ab, bv, fe);
    if (rs != 0) begin
      m_mode = 0; m_pix = 0; m_bank = 0; m_frames = 0; m_und = 0;
    end else if (ab != 0) begin
      m_mode = 0; m_pix = 0; m_frames = 0; m_und = 0;
    end else begin
      case (m_mode)
        0: if (st != 0) begin m_mode = 1; m_pix = 0; m_frames = 0; m_und = 0; end
        1: begin
          if (fe != 0 && m_und < 65535) m_und++;
          if (bv != 0) begin
            m_pix++;
            if (m_pix == XN * YN) begin m_pix = 0; m_mode = 2; end
          end
        end
        2: if (fe != 0) m_mode = 3;
        3: begin
          m_bank   = 1 - m_bank;
          m_frames = (m_frames + 1) % 65536;
          m_mode   = (NF != 0 && m_frames == NF) ? 4 : 1;
        end
        default: m_mode = m_mode;
      endcase
    end
  endtask

  initial begin
    int rs, st, ab, bv, fe;

    // ---------------- directed vector table ----------------
    add(0,0,0,0,0, 0,0,0,0,0,0,0,0,0);                       // reset state
    add(0,1,0,0,0, 0,0,0,0,0,0,0,0,0);                       // start
    for (int i = 0; i < 8; i++) add(0,0,0,1,0, 1,i%4,i/4,1,0,0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0,0,0,0,0,0);                       // READY
    add(0,0,0,1,0, 0,0,0,0,0,0,0,0,0);                       // bit_valid ignored
    add(0,0,0,0,1, 0,0,0,0,0,0,0,0,0);                       // frame_end
    add(0,0,0,0,0, 0,0,0,0,1,0,0,0,0);                       // SWAP pulse
    add(0,0,0,0,0, 0,0,0,1,0,1,1,0,0);                       // FILL bank 1
    for (int i = 0; i < 5; i++) add(0,0,0,1,0, 1,i%4,i/4,1,0,1,1,0,0);
    add(0,0,0,0,1, 0,1,1,1,0,1,1,0,0);                       // underrun
    add(0,0,0,0,0, 0,1,1,1,0,1,1,0,1);
    for (int i = 5; i < 8; i++) add(0,0,0,1,0, 1,i%4,i/4,1,0,1,1,0,1);
    add(0,0,0,0,1, 0,0,0,0,0,1,1,0,1);                       // READY + frame_end
    add(0,0,0,0,0, 0,0,0,0,1,1,1,0,1);                       // SWAP
    add(0,0,0,0,0, 0,0,0,0,0,0,2,1,1);                       // DONE
    add(0,1,0,1,0, 0,0,0,0,0,0,2,1,1);                       // start/bit ignored
    add(0,0,0,0,0, 0,0,0,0,0,0,2,1,1);
    add(0,0,1,0,0, 0,0,0,0,0,0,2,1,1);                       // abort
    add(0,0,0,0,0, 0,0,0,0,0,0,0,0,0);                       // IDLE
    add(0,1,0,0,0, 0,0,0,0,0,0,0,0,0);                       // start
    for (int i = 0; i < 7; i++) add(0,0,0,1,0, 1,i%4,i/4,1,0,0,0,0,0);
    add(0,0,0,1,1, 1,3,1,1,0,0,0,0,0);                       // last bit + frame_end
    add(0,0,0,0,0, 0,0,0,0,0,0,0,0,1);                       // READY, no swap
    add(0,0,0,0,1, 0,0,0,0,0,0,0,0,1);
    add(0,0,0,0,0, 0,0,0,0,1,0,0,0,1);                       // SWAP
    add(0,0,0,0,0, 0,0,0,1,0,1,1,0,1);
    for (int i = 0; i < 3; i++) add(0,0,0,1,0, 1,i,0,1,0,1,1,0,1);
    add(0,0,1,0,0, 0,3,0,1,0,1,1,0,1);                       // abort mid-fill
    add(0,0,0,0,0, 0,0,0,0,0,1,0,0,0);                       // IDLE keeps bank 1
    add(0,1,0,0,0, 0,0,0,0,0,1,0,0,0);
    for (int i = 0; i < 2; i++) add(0,0,0,1,0, 1,i,0,1,0,1,0,0,0);
    add(1,0,0,0,0, 0,2,0,1,0,1,0,0,0);                       // reset mid-fill
    add(0,0,0,0,0, 0,0,0,0,0,0,0,0,0);
    add(0,1,0,0,0, 0,0,0,0,0,0,0,0,0);
    add(0,0,0,1,0, 1,0,0,1,0,0,0,0,0);                       // refill from (0,0)
    add(0,0,0,1,0, 1,1,0,1,0,0,0,0,0);

    drive(1,0,0,0,0);
    repeat (2) @(negedge CLK_40);

    foreach (vecs[i]) begin
      @(negedge CLK_40);
      drive(vecs[i].rs, vecs[i].st, vecs[i].ab, vecs[i].bv, vecs[i].fe);
      #2;
      check_outputs($sformatf("vec%0d", i), vecs[i].we, vecs[i].x, vecs[i].y, vecs[i].spi,
                    vecs[i].sw, vecs[i].bk, vecs[i].fr, vecs[i].dn, vecs[i].und);
    end

    // ---------------- randomized phase against the model ----------------
    @(negedge CLK_40);
    drive(1,0,0,0,0);
    model_step(1,0,0,0,0);
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK_40);
      rs = ($urandom_range(299, 0) == 0) ? 1 : 0;
      ab = ($urandom_range(99, 0) == 0) ? 1 : 0;
      st = ($urandom_range(5, 0) == 0) ? 1 : 0;
      bv = ($urandom_range(3, 0) != 0) ? 1 : 0;
      fe = ($urandom_range(9, 0) == 0) ? 1 : 0;
      drive(rs, st, ab, bv, fe);
      #2;
      check_outputs($sformatf("rnd%0d", c),
                    (m_mode == 1 && bv != 0) ? 1 : 0, m_pix % XN, m_pix / XN,
                    (m_mode == 1) ? 1 : 0, (m_mode == 3) ? 1 : 0, m_bank, m_frames,
                    (m_mode == 4) ? 1 : 0, m_und);
      model_step(rs, st, ab, bv, fe);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
